// File: rtl/basic_arith_mac.sv
// basic_arith_mac
//   Sequential signed multiply-accumulate stage. Each accepted input word
//   carries two signed 9-bit operands; their product is formed by a 9-cycle
//   LSB-first shift-add multiplier and added into a saturating accumulator.
//   After BURST products the accumulated sum is offered on a valid/ready
//   output handshake.
//
// Ports
//   system1000       : clock, rising edge
//   system1000_rstn  : synchronous active-low reset
//   in_data[17:0]    : {sel0[8:0], sel1[8:0]}, both two's complement
//   in_valid         : in_data valid
//   in_ready         : block can accept a pair (IDLE only)
//   out_data         : signed accumulated sum (ACC_W bits)
//   out_valid        : out_data / out_ovf valid
//   out_ready        : downstream accepts the output
//   out_ovf          : saturation happened somewhere in this burst
module basic_arith_mac #(
  parameter int ACC_W = 24,
  parameter int BURST = 4
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic [17:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [7:0]       BURST_LAST = 8'(BURST - 1);
  localparam logic [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state_q,  state_d;
  logic [17:0]      mcand_q,  mcand_d;   // |a|, shifted left each iteration
  logic [8:0]       mplier_q, mplier_d;  // |b|, shifted right each iteration
  logic [17:0]      prod_q,   prod_d;    // unsigned magnitude of a*b
  logic [3:0]       iter_q,   iter_d;
  logic             neg_q,    neg_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic             ovf_q,    ovf_d;

  logic [8:0]       sel0, sel1;
  logic [8:0]       sel0_mag, sel1_mag;
  logic [17:0]      prod_signed;
  logic [ACC_W:0]   sum;

  assign sel0 = in_data[17:9];
  assign sel1 = in_data[8:0];

  // Negating -256 in 9 bits yields 9'h100, which read as unsigned is 256,
  // so the magnitude of every 9-bit operand fits without widening.
  assign sel0_mag = sel0[8] ? 9'(-sel0) : sel0;
  assign sel1_mag = sel1[8] ? 9'(-sel1) : sel1;

  // Product magnitude is at most 65536 and a negative product needs one
  // positive operand (max 255), so the signed 18-bit result is exact.
  assign prod_signed = neg_q ? 18'(-prod_q) : prod_q;

  // One guard bit above the accumulator: a disagreement between the two
  // top bits means the true sum left the ACC_W-bit signed range.
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-18){prod_signed[17]}}, prod_signed};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    iter_d   = iter_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = {9'd0, sel0_mag};
          mplier_d = sel1_mag;
          neg_d    = sel0[8] ^ sel1[8];
          prod_d   = '0;
          iter_d   = '0;
          state_d  = ST_MUL;
        end
      end

      ST_MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 4'd1;
        if (iter_q == 4'd8) begin
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == BURST_LAST) ? ST_OUT : ST_IDLE;
      end

      default: begin  // ST_OUT
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      iter_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      iter_q   <= iter_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs are forced quiet combinationally while reset is held, so they
  // read 0 even before the first reset edge has been seen.
  assign in_ready  = system1000_rstn && (state_q == ST_IDLE);
  assign out_valid = system1000_rstn && (state_q == ST_OUT);
  assign out_data  = system1000_rstn ? acc_q : '0;
  assign out_ovf   = out_valid && ovf_q;

endmodule

// File: doc/basic_arith_mac.md
# basic_arith_mac

Sequential signed multiply-accumulate stage in the BasicArithmetic datapath. It consumes the packed 18-bit `product0` operand pair: two signed 9-bit fields, `sel0` in bits [17:9] and `sel1` in bits [8:0]. It multiplies each pair with an iterative shift-add multiplier and accumulates `BURST` products into a saturating accumulator. Each completed sum is emitted over a valid/ready handshake.

## Interface

Parameters:
- `ACC_W`, default 24: accumulator and output width in bits. Legal range is `ACC_W >= 18`.
- `BURST`, default 4: number of products summed per output word. Legal range is 1..255.

Ports:
- `system1000`, in, 1: clock. All logic is rising-edge.
- `system1000_rstn`, in, 1: reset. Synchronous, active-low.
- `in_data`, in, 18: packed pair, `{sel0[8:0], sel1[8:0]}`, both two's complement.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a pair.
- `out_data`, out, `ACC_W`: signed accumulated sum.
- `out_valid`, out, 1: `out_data` and `out_ovf` are valid.
- `out_ready`, in, 1: downstream accepts the output.
- `out_ovf`, out, 1: saturation occurred during this burst (sticky within the burst).

## Operation

- The FSM has four states: IDLE, MUL, ACC, OUT.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` and `in_ready` are both high, the block:
    - latches operands `a`=sel0 and `b`=sel1;
    - stores `|a|` and `|b|` as 9-bit unsigned values (|−256| = 256 fits);
    - stores `neg = a[8]^b[8]`;
    - clears the partial product and the iteration counter;
    - moves to MUL.
- MUL:
  - Runs exactly 9 iterations, one per cycle, LSB-first shift-add.
  - After the 9th iteration the unsigned 18-bit magnitude is complete; the block moves to ACC.
- ACC:
  - Forms the product `p = neg ? −mag : mag` as an 18-bit signed value. The range is −65280..65536, exact with no truncation.
  - Computes `sum = acc + sext(p)` at `ACC_W+1` bits.
  - If `sum > 2^(ACC_W−1)−1`, `acc` clamps to the max value and `ovf` is set. If `sum < −2^(ACC_W−1)`, `acc` clamps to the min value and `ovf` is set. Otherwise `acc = sum`.
  - Increments the burst count. If the count reaches `BURST`, the block moves to OUT; otherwise it returns to IDLE.
- OUT:
  - `out_valid`=1; `out_data`=`acc`; `out_ovf`=`ovf`.
  - All three are held stable while `out_ready`=0.
  - On the handshake, `acc`, `ovf` and the burst count clear, and the block moves to IDLE.
- `in_ready` is 1 only in IDLE, so input and output handshakes never coincide.
- `in_data` is ignored when `in_ready`=0. `in_valid` may drop at any time without effect.

## Timing

- Reset (`system1000_rstn`=0 at a clock edge):
  - State becomes IDLE; `acc`, `ovf`, burst count and iteration counter are 0.
  - While in reset: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_ovf`=0.
  - `in_ready`=1 in the first cycle after reset is released.
- Reset asserted in any state, including mid-MUL or OUT, discards all in-flight data, including any pending output word.
- Operand accept in cycle T:
  - MUL occupies T+1..T+9.
  - ACC occupies T+10.
  - In cycle T+11, either IDLE with `in_ready`=1, or OUT with `out_valid`=1 if this was the `BURST`th operand.
- Throughput is one pair per 11 cycles. A full burst takes 11·`BURST` cycles plus output stall.
- Output handshake in cycle U: `out_valid`=0 and `in_ready`=1 in cycle U+1.
- `out_ovf` is only meaningful while `out_valid`=1. It is 0 otherwise.

## Test plan

- Reset: hold `system1000_rstn`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0, `out_ovf`=0. After release, `in_ready`=1 and the first accept happens in the next cycle.
- Burst, `BURST`=4, `ACC_W`=24: pairs (3,5), (−4,7), (−256,−256), (255,−1), each presented as soon as `in_ready`=1 → `out_data`=65268, `out_ovf`=0. `out_valid` rises exactly 11 cycles after the 4th accept.
- Backpressure: `out_ready`=0 for 20 cycles while `out_valid`=1 → `out_data`/`out_ovf` stable, `in_ready`=0, `in_valid` ignored. On `out_ready`=1, the handshake completes and `in_ready`=1 in the next cycle. The next burst starts from `acc`=0.
- Saturation, `ACC_W`=18: four pairs (−256,−256) → `out_data`=131071, `out_ovf`=1. Follow with a burst of four pairs (1,1) → `out_data`=4, `out_ovf`=0.
- Negative clamp, `ACC_W`=18: four pairs (−256,255) → `out_data`=−131072, `out_ovf`=1.
- Reset mid-operation: accept (7,7), then assert reset at T+5 → no output. After release, a burst of four pairs (1,2) gives `out_data`=8.
